main_memory: RTL and testbench

- Multi-cycle word-addressed backing memory sitting directly downstream of the data-cache controller.
- Serves read misses (refill data plus `ready`) and write-through stores (`ready` on commit).
- Fixed, parameterised access latency models slow main memory, so the controller's stall path is exercised.
- One outstanding request at a time; a one-cycle `ready` pulse closes every transaction.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_array.sv | 31 +++
 rtl/main_memory.sv | 101 ++++++++++
 tb/tb_main_memory.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the backing memory and the data-cache controller:
// FSM encodings, address split and storage geometry.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int WORD_ADDR_LSB = 2;
  localparam int MEM_DEPTH     = 256;
  localparam int TAG_W         = 3;
  localparam int IDX_W         = 5;
  localparam int WADDR_W       = TAG_W + IDX_W;

endpackage

// File: rtl/mem_array.sv
// Synchronous word storage: one write port and a registered read port whose
// output holds until the next read enable. Only the read register is reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int AW = $clog2(MEM_DEPTH),
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/main_memory.sv
// Fixed-latency backing memory behind the data cache: accepts one read or
// write at a time and closes each with a single-cycle ready pulse.
module main_memory
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_mem,
  input  logic                  write_mem,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  busy
);

  localparam int         WA_W     = ADDR_WIDTH - WORD_ADDR_LSB;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                state;
  logic [3:0]            cnt;
  op_t                   req_op;
  logic [WA_W-1:0]       req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  last;
  logic                  arr_we;
  logic                  arr_re;
  logic                  unused_byte_bits;

  // Byte-lane bits carry no meaning for a word-wide memory.
  assign unused_byte_bits = ^addr[WORD_ADDR_LSB-1:0];

  // The array access happens on the same edge that moves BUSY -> DONE, so the
  // read register presents the refill word exactly while ready is high.
  assign last   = (state == BUSY) && (cnt == 4'd0);
  assign arr_we = last && (req_op == OP_WR);
  assign arr_re = last && (req_op == OP_RD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      req_op    <= OP_RD;
      req_addr  <= '0;
      req_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (write_mem || read_mem) begin
            // Write wins when both are raised, matching the controller decode.
            req_op    <= write_mem ? OP_WR : OP_RD;
            req_addr  <= addr[ADDR_WIDTH-1:WORD_ADDR_LSB];
            req_wdata <= wdata;
            cnt       <= CNT_INIT;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  mem_array #(
    .AW (WA_W),
    .DW (DATA_WIDTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (req_addr),
    .wdata (req_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_main_memory.sv
// Directed scoreboard bench for main_memory: each issued request queues its
// expected ready cycle and rdata; a negedge monitor checks every ready pulse.
module tb_main_memory;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_mem;
  logic        write_mem;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  main_memory #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_mem  (read_mem),
    .write_mem (write_mem),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ready === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: got ready=1 expected no pending request (cyc %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ready_cycle", cyc, e.cyc);
        chk("ready_rdata", rdata, e.data);
        chk("busy_at_ready", {31'b0, busy}, 32'd0);
      end
    end
  end

  // Issue one request from a negedge in IDLE; returns at the negedge after
  // the DONE cycle so the next call is accepted from IDLE.
  task automatic xact(input logic rd, input logic wr, input logic [9:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input bit drop);
    int bc;
    bit seen;
    bc = 0;
    seen = 0;
    read_mem = rd; write_mem = wr; addr = a; wdata = d;
    q.push_back('{cyc + 1 + LAT, exp_rd});
    @(posedge clk);
    @(negedge clk);
    if (!drop) begin read_mem = 0; write_mem = 0; end
    for (int i = 0; i < 20; i++) begin
      if (ready) begin seen = 1; break; end
      if (busy) bc++;
      if (drop && i == 1) begin
        addr = a ^ 10'h060; wdata = ~d; read_mem = 0; write_mem = 0;
      end
      @(negedge clk);
    end
    chk("ready_seen", {31'b0, seen}, 32'd1);
    chk("busy_cycles", bc, LAT);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; read_mem = 0; write_mem = 0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_quiet", {30'b0, ready, busy}, 32'd0);
    end
    chk("idle_rdata", rdata, 32'd0);

    // Preload word 0x15 then read it back with full latency.
    xact(0, 1, 10'h054, 32'hDEADBEEF, 32'h0, 0);
    xact(1, 0, 10'h054, 32'h0, 32'hDEADBEEF, 0);
    repeat (3) @(negedge clk);
    chk("rdata_held", rdata, 32'hDEADBEEF);

    // Top word, write then read; a write leaves rdata alone.
    xact(0, 1, 10'h3FC, 32'h12345678, 32'hDEADBEEF, 0);
    xact(1, 0, 10'h3FC, 32'h0, 32'h12345678, 0);

    // Both strobes: behaves as a write.
    xact(1, 1, 10'h010, 32'hA5A5A5A5, 32'h12345678, 0);
    chk("both_rdata_kept", rdata, 32'h12345678);
    xact(1, 0, 10'h010, 32'h0, 32'hA5A5A5A5, 0);

    // Inputs changed and request dropped mid-BUSY: only 0x020 is written.
    xact(0, 1, 10'h040, 32'h0BADBEEF, 32'hA5A5A5A5, 0);
    xact(0, 1, 10'h020, 32'hCAFEF00D, 32'hA5A5A5A5, 1);
    xact(1, 0, 10'h020, 32'h0, 32'hCAFEF00D, 0);
    xact(1, 0, 10'h040, 32'h0, 32'h0BADBEEF, 0);

    // Reset in the middle of a write aborts it without commit.
    xact(0, 1, 10'h030, 32'h11111111, 32'h0BADBEEF, 0);
    read_mem = 0; write_mem = 1; addr = 10'h030; wdata = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    write_mem = 0;
    chk("abort_busy_before", {31'b0, busy}, 32'd1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_ready", {31'b0, ready}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_ready", {31'b0, ready}, 32'd0);
    end
    xact(1, 0, 10'h030, 32'h0, 32'h11111111, 0);

    @(negedge clk);
    chk("sb_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard so a hung DUT still reaches a summary.
  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: got no completion expected finish within bound");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
